regfile_wb_ctrl: RTL and testbench

//  Owns the single write port of the 32x32 register file. After reset it sweeps every register to zero,

---
 rtl/regfile_ctrl_pkg.sv | 20 ++
 rtl/regfile_rr_arb.sv | 25 ++
 rtl/regfile_wb_ctrl.sv | 103 ++++++++++
 tb/tb_regfile_wb_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared types, sizes and the round-robin pick used by the regfile write-port controller.
package regfile_ctrl_pkg;
   typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_e;
   localparam int REG_AW  = 5;
   localparam int REG_DW  = 32;
   localparam int REG_NUM = 32;
   localparam int MAX_REQ = 8;
   // First valid requester at or after ptr, wrapping modulo n; result is one-hot or zero.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid, input logic [2:0] ptr,
                                                  input int n);
      logic [MAX_REQ-1:0] g;
      int idx;
      g = '0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = (int'(ptr) + k) % n;
         if (k < n && g == '0 && valid[idx[2:0]]) g[idx[2:0]] = 1'b1;
      end
      return g;
   endfunction
endpackage

// File: rtl/regfile_rr_arb.sv
// regfile_rr_arb: combinational one-hot round-robin grant with a registered rotate pointer.
module regfile_rr_arb
   import regfile_ctrl_pkg::*;
#(
   parameter int N = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en_i,
   input  logic [N-1:0] valid_i,
   output logic [N-1:0] grant_o
);
   logic [2:0]         ptr_q, ptr_d;
   logic [MAX_REQ-1:0] pick;
   always_comb begin
      pick    = rr_pick(MAX_REQ'(valid_i), ptr_q, N);
      grant_o = en_i ? pick[N-1:0] : '0;
      ptr_d   = ptr_q;
      for (int i = 0; i < N; i++)
         if (grant_o[i]) ptr_d = (i == N - 1) ? 3'd0 : 3'(i + 1);
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) ptr_q <= '0;
      else        ptr_q <= ptr_d;
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: regfile write-port owner - zero sweep after reset, then round-robin writeback arbitration.
// Define REGFILE_FWD_EN to repair stale read data on a same-cycle write/read address hit.
module regfile_wb_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int NUM_REGS = REG_NUM,
   parameter int AW       = REG_AW,
   parameter int DW       = REG_DW
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*DW-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  init_done,
   output logic                  wr_en,
   output logic [AW-1:0]         wr_addr,
   output logic [DW-1:0]         wr_data,
   input  logic [AW-1:0]         rd_addra,
   input  logic [AW-1:0]         rd_addrb,
   input  logic [DW-1:0]         rf_dataa,
   input  logic [DW-1:0]         rf_datab,
   output logic [DW-1:0]         rdata_a,
   output logic [DW-1:0]         rdata_b
);
   localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d, sel_addr;
   logic [DW-1:0] wr_data_q, wr_data_d, sel_data;
   logic          sweep, transfer;
   regfile_rr_arb #(.N(NUM_REQ)) u_arb (
      .clock   (clock),
      .reset   (reset),
      .en_i    (state_q == RUN),
      .valid_i (req_valid),
      .grant_o (req_ready)
   );
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (req_ready[i]) begin
            sel_addr = req_addr[i*AW +: AW];
            sel_data = req_data[i*DW +: DW];
         end
      sweep     = state_q == INIT;
      transfer  = |req_ready;
      state_d   = (sweep && cnt_q == LAST) ? RUN : state_q;
      cnt_d     = sweep ? cnt_q + 1'b1 : cnt_q;
      wr_en_d   = sweep | transfer;
      wr_addr_d = sweep ? cnt_q : transfer ? sel_addr : wr_addr_q;
      wr_data_d = sweep ? '0 : transfer ? sel_data : wr_data_q;
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state_q   <= INIT;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   assign init_done = state_q == RUN;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
`ifdef REGFILE_FWD_EN
   // The regfile returns the old value on a same-cycle hit; replay the written word one cycle later.
   logic          fwd_a_q, fwd_b_q;
   logic [DW-1:0] fwd_data_a_q, fwd_data_b_q;
   logic          hit_a, hit_b;
   assign hit_a = wr_en_q && wr_addr_q == rd_addra;
   assign hit_b = wr_en_q && wr_addr_q == rd_addrb;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         fwd_a_q      <= 1'b0;
         fwd_b_q      <= 1'b0;
         fwd_data_a_q <= '0;
         fwd_data_b_q <= '0;
      end else begin
         fwd_a_q <= hit_a;
         fwd_b_q <= hit_b;
         if (hit_a) fwd_data_a_q <= wr_data_q;
         if (hit_b) fwd_data_b_q <= wr_data_q;
      end
   assign rdata_a = fwd_a_q ? fwd_data_a_q : rf_dataa;
   assign rdata_b = fwd_b_q ? fwd_data_b_q : rf_datab;
`else
   logic unused_rd;
   assign unused_rd = ^{rd_addra, rd_addrb};
   assign rdata_a   = rf_dataa;
   assign rdata_b   = rf_datab;
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed vectors for the init sweep, round-robin arbitration, async reset and forwarding.
module tb_regfile_wb_ctrl;
   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;
`ifdef REGFILE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N*AW-1:0]   req_addr = '0;
   logic [N*DW-1:0]   req_data = '0;
   logic [N-1:0]      req_ready;
   logic              init_done, wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic [AW-1:0]     rd_addra = '0, rd_addrb = '0;
   logic [DW-1:0]     rf_dataa = 32'h1111_1111, rf_datab = 32'h2222_2222;
   logic [DW-1:0]     rdata_a, rdata_b;
   int nvec = 0;
   int nerr = 0;
   always #5 clock = ~clock;
   regfile_wb_ctrl dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .init_done(init_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addra(rd_addra), .rd_addrb(rd_addrb), .rf_dataa(rf_dataa), .rf_datab(rf_datab),
      .rdata_a(rdata_a), .rdata_b(rdata_b)
   );
   task automatic step;
      @(posedge clock);
      #1;
   endtask
   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask
   task automatic test_reset;
      set_req(0, 5'd5, 32'hAAAA_0005);
      set_req(1, 5'd6, 32'hBBBB_0006);
      set_req(2, 5'd7, 32'hCCCC_0007);
      req_valid = '1;
      #3;
      nvec++; if (wr_en !== 1'b0) begin nerr++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
      nvec++; if (wr_addr !== 5'd0) begin nerr++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
      nvec++; if (wr_data !== 32'd0) begin nerr++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
      nvec++; if (init_done !== 1'b0) begin nerr++; $display("FAIL reset_init_done got %b want 0", init_done); end
      nvec++; if (req_ready !== 3'b000) begin nerr++; $display("FAIL reset_ready got %b want 000", req_ready); end
   endtask
   task automatic test_init;
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 32; i++) begin
         step;
         nvec++; if (wr_en !== 1'b1) begin nerr++; $display("FAIL init_wr_en[%0d] got %b want 1", i, wr_en); end
         nvec++; if (wr_addr !== 5'(i)) begin nerr++; $display("FAIL init_addr[%0d] got %0d want %0d", i, wr_addr, i); end
         nvec++; if (wr_data !== 32'd0) begin nerr++; $display("FAIL init_data[%0d] got %h want 0", i, wr_data); end
         nvec++; if (init_done !== (i == 31)) begin nerr++; $display("FAIL init_done[%0d] got %b want %b", i, init_done, i == 31); end
         nvec++; if (req_ready !== ((i == 31) ? 3'b001 : 3'b000)) begin nerr++; $display("FAIL init_ready[%0d] got %b", i, req_ready); end
      end
   endtask
   task automatic test_all_valid;
      logic [DW-1:0] d [3] = '{32'hAAAA_0005, 32'hBBBB_0006, 32'hCCCC_0007};
      for (int g = 0; g < 3; g++) begin
         nvec++; if (req_ready !== 3'(1 << g)) begin nerr++; $display("FAIL all_ready[%0d] got %b want %b", g, req_ready, 3'(1 << g)); end
         step;
         nvec++; if (wr_en !== 1'b1) begin nerr++; $display("FAIL all_wr_en[%0d] got %b want 1", g, wr_en); end
         nvec++; if (wr_addr !== 5'(5 + g)) begin nerr++; $display("FAIL all_addr[%0d] got %0d want %0d", g, wr_addr, 5 + g); end
         nvec++; if (wr_data !== d[g]) begin nerr++; $display("FAIL all_data[%0d] got %h want %h", g, wr_data, d[g]); end
      end
      nvec++; if (req_ready !== 3'b001) begin nerr++; $display("FAIL all_wrap got %b want 001", req_ready); end
      req_valid = '0;
      #1;
      nvec++; if (req_ready !== 3'b000) begin nerr++; $display("FAIL idle_ready got %b want 000", req_ready); end
      step;
      nvec++; if (wr_en !== 1'b0) begin nerr++; $display("FAIL idle_wr_en got %b want 0", wr_en); end
   endtask
   task automatic test_single_then_pair;
      set_req(1, 5'd8, 32'h0000_0808);
      req_valid = 3'b010;
      #1;
      for (int c = 0; c < 4; c++) begin
         nvec++; if (req_ready !== 3'b010) begin nerr++; $display("FAIL single_ready[%0d] got %b want 010", c, req_ready); end
         step;
         nvec++; if (wr_en !== 1'b1 || wr_addr !== 5'd8) begin nerr++; $display("FAIL single_wr[%0d] got en=%b addr=%0d want en=1 addr=8", c, wr_en, wr_addr); end
      end
      set_req(0, 5'd10, 32'h0A0A_000A);
      set_req(2, 5'd12, 32'h0C0C_000C);
      req_valid = 3'b101;
      #1;
      nvec++; if (req_ready !== 3'b100) begin nerr++; $display("FAIL pair_first got %b want 100", req_ready); end
      step;
      nvec++; if (wr_addr !== 5'd12 || wr_data !== 32'h0C0C_000C) begin nerr++; $display("FAIL pair_wr2 got %0d/%h want 12/0c0c000c", wr_addr, wr_data); end
      nvec++; if (req_ready !== 3'b001) begin nerr++; $display("FAIL pair_second got %b want 001", req_ready); end
      step;
      nvec++; if (wr_addr !== 5'd10 || wr_data !== 32'h0A0A_000A) begin nerr++; $display("FAIL pair_wr0 got %0d/%h want 10/0a0a000a", wr_addr, wr_data); end
      req_valid = '0;
      step;
   endtask
   task automatic test_reset_mid;
      req_valid = '1;
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) step;
      nvec++; if (wr_addr !== 5'd9) begin nerr++; $display("FAIL mid_sweep_addr got %0d want 9", wr_addr); end
      reset = 1'b0;
      #1;
      nvec++; if (wr_en !== 1'b0 || wr_addr !== 5'd0) begin nerr++; $display("FAIL mid_async got en=%b addr=%0d want 0/0", wr_en, wr_addr); end
      @(negedge clock);
      reset = 1'b1;
      step;
      nvec++; if (wr_en !== 1'b1 || wr_addr !== 5'd0) begin nerr++; $display("FAIL mid_restart got en=%b addr=%0d want 1/0", wr_en, wr_addr); end
      nvec++; if (req_ready !== 3'b000) begin nerr++; $display("FAIL mid_ready got %b want 000", req_ready); end
      for (int i = 1; i < 32; i++) step;
      nvec++; if (init_done !== 1'b1 || wr_addr !== 5'd31) begin nerr++; $display("FAIL mid_done got done=%b addr=%0d want 1/31", init_done, wr_addr); end
      nvec++; if (req_ready !== 3'b001) begin nerr++; $display("FAIL mid_ptr got %b want 001", req_ready); end
      step;
      nvec++; if (wr_en !== 1'b1 || wr_addr !== 5'd10) begin nerr++; $display("FAIL run_wr got en=%b addr=%0d want 1/10", wr_en, wr_addr); end
      reset = 1'b0;
      #1;
      nvec++; if (wr_en !== 1'b0) begin nerr++; $display("FAIL run_async got %b want 0", wr_en); end
      nvec++; if (init_done !== 1'b0 || req_ready !== 3'b000) begin nerr++; $display("FAIL run_reset got done=%b ready=%b want 0/000", init_done, req_ready); end
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 32; i++) step;
      nvec++; if (req_ready !== 3'b001) begin nerr++; $display("FAIL run_ptr got %b want 001", req_ready); end
      req_valid = '0;
      step;
   endtask
   task automatic test_forward;
      set_req(0, 5'd9, 32'hDEAD_BEEF);
      req_valid = 3'b001;
      step;
      req_valid = '0;
      rd_addra = 5'd9;
      rd_addrb = 5'd4;
      #1;
      nvec++; if (rdata_a !== 32'h1111_1111) begin nerr++; $display("FAIL fwd_pre got %h want 11111111", rdata_a); end
      step;
      nvec++; if (rdata_a !== (FWD ? 32'hDEAD_BEEF : 32'h1111_1111)) begin nerr++; $display("FAIL fwd_a9 got %h", rdata_a); end
      nvec++; if (rdata_b !== 32'h2222_2222) begin nerr++; $display("FAIL fwd_b9 got %h want 22222222", rdata_b); end
      step;
      nvec++; if (rdata_a !== 32'h1111_1111) begin nerr++; $display("FAIL fwd_clear got %h want 11111111", rdata_a); end
      set_req(0, 5'd3, 32'h3333_0003);
      req_valid = 3'b001;
      rd_addra = 5'd3;
      step;
      req_valid = '0;
      step;
      nvec++; if (rdata_a !== (FWD ? 32'h3333_0003 : 32'h1111_1111)) begin nerr++; $display("FAIL fwd_a3 got %h", rdata_a); end
      nvec++; if (rdata_b !== 32'h2222_2222) begin nerr++; $display("FAIL fwd_b4 got %h want 22222222", rdata_b); end
      set_req(0, 5'd4, 32'h4444_0004);
      req_valid = 3'b001;
      step;
      req_valid = '0;
      rf_dataa = 32'h5555_5555;
      step;
      nvec++; if (rdata_a !== 32'h5555_5555) begin nerr++; $display("FAIL fwd_a_pass got %h want 55555555", rdata_a); end
      nvec++; if (rdata_b !== (FWD ? 32'h4444_0004 : 32'h2222_2222)) begin nerr++; $display("FAIL fwd_b4w got %h", rdata_b); end
   endtask
   initial begin
      test_reset;
      test_init;
      test_all_valid;
      test_single_then_pair;
      test_reset_mid;
      test_forward;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
